// File: rtl/mips_enc_pkg.sv
// Shared MIPS encoder definitions: format codes, field positions, default load address
// and the field-packing / field-legality helpers.
package mips_enc_pkg;

   localparam logic [1:0] FMT_R   = 2'd0;
   localparam logic [1:0] FMT_I   = 2'd1;
   localparam logic [1:0] FMT_J   = 2'd2;
   localparam logic [1:0] FMT_NOP = 2'd3;

   localparam int unsigned INSTR_W   = 32;
   localparam int unsigned OPC_LSB   = 26;
   localparam int unsigned RS_LSB    = 21;
   localparam int unsigned RT_LSB    = 16;
   localparam int unsigned RD_LSB    = 11;
   localparam int unsigned SHAMT_LSB = 6;
   localparam int unsigned FUNCT_LSB = 0;
   localparam int unsigned IMM_LSB   = 0;
   localparam int unsigned JADD_LSB  = 0;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_3000;

   // Packs one instruction description into a word; fields unused by the format are ignored.
   function automatic logic [31:0] pack_instr(
      input logic [1:0]  fmt,
      input logic [5:0]  opcode,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [4:0]  rd,
      input logic [4:0]  shamt,
      input logic [5:0]  funct,
      input logic [15:0] imm,
      input logic [25:0] jadd
   );
      logic [31:0] w;
      w = '0;
      case (fmt)
         FMT_R: begin
            w[OPC_LSB +: 6]   = opcode;
            w[RS_LSB +: 5]    = rs;
            w[RT_LSB +: 5]    = rt;
            w[RD_LSB +: 5]    = rd;
            w[SHAMT_LSB +: 5] = shamt;
            w[FUNCT_LSB +: 6] = funct;
         end
         FMT_I: begin
            w[OPC_LSB +: 6]  = opcode;
            w[RS_LSB +: 5]   = rs;
            w[RT_LSB +: 5]   = rt;
            w[IMM_LSB +: 16] = imm;
         end
         FMT_J: begin
            w[OPC_LSB +: 6]   = opcode;
            w[JADD_LSB +: 26] = jadd;
         end
         default: w = '0;
      endcase
      return w;
   endfunction

   // True when the opcode cannot belong to the stated format.
   function automatic logic field_bad(input logic [1:0] fmt, input logic [5:0] opcode);
      logic bad;
      bad = 1'b0;
      case (fmt)
         FMT_R:   bad = (opcode != 6'd0);
         FMT_I:   bad = (opcode == 6'd0) || (opcode == 6'd2) || (opcode == 6'd3);
         FMT_J:   bad = (opcode != 6'd2) && (opcode != 6'd3);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage; head word is read straight from the array,
// so a pushed word appears at rdata no earlier than the following cycle.
module sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push && !full && !flush;
   assign pop_ok  = pop && !empty && !flush;
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Pointer and occupancy next-state; power-of-two depth lets pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is cleared on reset so the head reads zero while empty after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// MIPS instruction encoder: packs field descriptions into words, buffers them and emits
// them with sequential byte addresses. Optional opcode/format check under FIELD_CHECK_EN.
module instr_encoder
   import mips_enc_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             fmt,
   input  logic [5:0]             opcode,
   input  logic [4:0]             rs,
   input  logic [4:0]             rt,
   input  logic [4:0]             rd,
   input  logic [4:0]             shamt,
   input  logic [5:0]             funct,
   input  logic [15:0]            imm,
   input  logic [25:0]            jadd,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_instr,
   output logic [31:0]            out_addr,
   output logic [$clog2(DEPTH):0] count,
   output logic                   err
);

   logic [31:0] word_c;
   logic        push_c, pop_c;
   logic        full, empty;
   logic [31:0] addr_q, addr_d;

   assign word_c    = pack_instr(fmt, opcode, rs, rt, rd, shamt, funct, imm, jadd);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push_c    = in_valid && in_ready && !flush;
   assign pop_c     = out_valid && out_ready && !flush;
   assign out_addr  = addr_q;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (INSTR_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (push_c),
      .pop   (pop_c),
      .wdata (word_c),
      .rdata (out_instr),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // Byte address of the head word: advances one word per pop, wraps modulo 2^32.
   always_comb begin
      addr_d = addr_q;
      if (flush)      addr_d = BASE_ADDR;
      else if (pop_c) addr_d = addr_q + 32'd4;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) addr_q <= BASE_ADDR;
      else       addr_q <= addr_d;
   end

`ifdef FIELD_CHECK_EN
   logic err_q, err_d;

   // Sticky until reset; flush deliberately leaves it alone.
   always_comb begin
      err_d = err_q;
      if (push_c && field_bad(fmt, opcode)) err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: scoreboard of expected words, address and err model.
module tb_instr_encoder;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h0000_3000;
`ifdef FIELD_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready, err;
   logic [1:0]  fmt;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   logic [25:0] jadd;
   logic [31:0] out_instr, out_addr;
   logic [2:0]  count;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] sb[$];
   logic [31:0] exp_addr = BASE;
   logic        exp_err  = 1'b0;
   bit          acc;

   always #5 clk = ~clk;

   instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
      .imm(imm), .jadd(jadd), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr), .count(count), .err(err)
   );

   function automatic logic [31:0] model_word(input logic [1:0] f, input logic [5:0] op,
      input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
      input logic [5:0] fn, input logic [15:0] im, input logic [25:0] ja);
      case (f)
         2'd0:    return {op, s, t, d, sh, fn};
         2'd1:    return {op, s, t, im};
         2'd2:    return {op, ja};
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit model_bad(input logic [1:0] f, input logic [5:0] op);
      if (f == 2'd0) return op != 6'd0;
      if (f == 2'd1) return op == 6'd0 || op == 6'd2 || op == 6'd3;
      if (f == 2'd2) return !(op == 6'd2 || op == 6'd3);
      return 1'b0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: sample at negedge against the scoreboard, then step to just past posedge.
   task automatic tick(output bit accepted);
      logic [31:0] w;
      @(negedge clk);
      chk("count", 32'(count), 32'(sb.size()));
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(sb.size() != int'(DEPTH)));
      chk("err", 32'(err), 32'(exp_err));
      accepted = in_valid && in_ready && !flush;
      if (flush) begin
         sb.delete();
         exp_addr = BASE;
      end else begin
         if (out_valid && out_ready && sb.size() != 0) begin
            w = sb.pop_front();
            chk("out_instr", out_instr, w);
            chk("out_addr", out_addr, exp_addr);
            exp_addr = exp_addr + 32'd4;
         end
         if (accepted) begin
            sb.push_back(model_word(fmt, opcode, rs, rt, rd, shamt, funct, imm, jadd));
            if (CHK_EN && model_bad(fmt, opcode)) exp_err = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_fields(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
      input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
      input logic [15:0] im, input logic [25:0] ja);
      fmt = f; opcode = op; rs = s; rt = t; rd = d; shamt = sh; funct = fn; imm = im; jadd = ja;
   endtask

   // Present the current fields until accepted, with a bounded wait.
   task automatic send_cur();
      bit a;
      int n;
      in_valid = 1'b1;
      n = 0;
      a = 1'b0;
      while (!a && n < 50) begin
         tick(a);
         n++;
      end
      if (!a) chk("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_rand();
      set_fields(2'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom));
      send_cur();
   endtask

   task automatic idle(input int n);
      bit a;
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) tick(a);
   endtask

   task automatic hard_reset();
      reset = 1'b1;
      #1;
      sb.delete();
      exp_addr = BASE;
      exp_err  = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      set_fields(2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_instr", out_instr, 32'h0);
      chk("rst_out_addr", out_addr, BASE);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Test-plan words streamed back to back with the sink always ready.
      out_ready = 1'b1;
      set_fields(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'hFFFF, 26'h3FFFFFF);
      send_cur();
      chk("r_word", out_instr, 32'h0022_1821);
      chk("r_addr", out_addr, 32'h0000_3000);
      set_fields(2'd1, 6'h0D, 5'd0, 5'd2, 5'd31, 5'd31, 6'h3F, 16'h1234, 26'h3FFFFFF);
      send_cur();
      chk("i_word", out_instr, 32'h3402_1234);
      chk("i_addr", out_addr, 32'h0000_3004);
      set_fields(2'd2, 6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0000C00);
      send_cur();
      chk("j_word", out_instr, 32'h0800_0C00);
      chk("j_addr", out_addr, 32'h0000_3008);
      set_fields(2'd3, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF);
      send_cur();
      chk("nop_word", out_instr, 32'h0);
      idle(2);

      // Fill with the sink stalled: fifth word must be held until space opens.
      hard_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_rand();
      chk("full_count", 32'(count), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      set_fields(2'd1, 6'h23, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'hBEEF, 26'd0);
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(acc);
         chk("held_push", 32'(acc), 32'd0);
         chk("stall_instr_stable", out_addr, 32'h0000_3000);
      end
      out_ready = 1'b1;
      send_cur();
      idle(6);
      chk("drain_addr_end", out_addr, 32'h0000_3014);

      // Continuous push and pop: occupancy stays at one word.
      for (int i = 0; i < 20; i++) begin
         send_rand();
         chk("stream_count", 32'(count), 32'd1);
      end
      idle(2);

      // Flush with three words buffered and a push pending.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_rand();
      in_valid = 1'b1;
      flush = 1'b1;
      tick(acc);
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_addr", out_addr, 32'h0000_3000);
      out_ready = 1'b1;
      set_fields(2'd0, 6'h00, 5'd7, 5'd8, 5'd9, 5'd2, 6'h00, 16'd0, 26'd0);
      send_cur();
      chk("post_flush_word", out_instr, 32'h00E8_4880);
      chk("post_flush_addr", out_addr, 32'h0000_3000);
      idle(2);

      // Illegal R-type opcode: word still enqueued; err sticky across flush.
      hard_reset();
      set_fields(2'd0, 6'h08, 5'd1, 5'd1, 5'd1, 5'd0, 6'h00, 16'd0, 26'd0);
      send_cur();
      chk("bad_word", out_instr, 32'h2021_0800);
      idle(1);
      chk("err_after_bad", 32'(err), CHK_EN ? 32'd1 : 32'd0);
      flush = 1'b1;
      tick(acc);
      flush = 1'b0;
      chk("err_after_flush", 32'(err), CHK_EN ? 32'd1 : 32'd0);

      // Reset during a drain: outputs return to reset values without a clock edge.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_rand();
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick(acc);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_instr", out_instr, 32'h0);
      chk("mid_rst_out_addr", out_addr, BASE);
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_err", 32'(err), 32'd0);
      hard_reset();
      send_rand();
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
